// File: rtl/fb_io_ctrl.sv
// fb_io_ctrl: memory-mapped I/O controller that sits between the core's load/store
// port and three targets: a keyboard receive FIFO, a terminal transmit register and
// main memory.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   data_src[1:0]   decoded target: 00 status, 01 tx data, 10 kbd rx, 11 memory
//   rd_en, wr_en    one-cycle load / store strobes from the core
//   wdata[31:0]     store data
//   mem_rdata[31:0] memory read data (passed through on data_src==11)
//   mem_we          memory write enable
//   rdata[31:0]     combinational load data to the core
//   kbd_valid/kbd_data/kbd_ready   keyboard byte handshake into the rx FIFO
//   term_valid/term_data/term_ready terminal byte handshake out of the tx register
//
// Status word: bit0 rx_nonempty, bit1 rx_full, bit2 tx_busy, bit3 tx_overrun
// (sticky, write-1-to-clear), bits[8:4] rx_count, all other bits zero.
module fb_io_ctrl #(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  data_src,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        term_valid,
    output logic [7:0]  term_data,
    input  logic        term_ready
);

    localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] SRC_STATUS = 2'b00;
    localparam logic [1:0] SRC_TX     = 2'b01;
    localparam logic [1:0] SRC_RX     = 2'b10;
    localparam logic [1:0] SRC_MEM    = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } tx_state_t;

    // Receive FIFO state
    logic [7:0]    fifo_q [RX_DEPTH];
    logic [7:0]    fifo_d [RX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Transmit state
    tx_state_t     state_q, state_d;
    logic [7:0]    tx_buf_q, tx_buf_d;
    logic          overrun_q, overrun_d;

    logic          rx_empty;
    logic          rx_full;
    logic          push;
    logic          pop;
    logic          tx_wr;
    logic          status_wr;
    logic [31:0]   status_word;

    // Only byte lane 0 and the W1C bit of wdata are architecturally meaningful.
    logic          unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:8];

    assign rx_empty  = (count_q == '0);
    assign rx_full   = (count_q == CW'(RX_DEPTH));
    assign kbd_ready = !rx_full;

    assign push      = kbd_valid && kbd_ready;
    assign pop       = rd_en && (data_src == SRC_RX) && !rx_empty;
    assign tx_wr     = wr_en && (data_src == SRC_TX);
    assign status_wr = wr_en && (data_src == SRC_STATUS);

    assign mem_we     = wr_en && (data_src == SRC_MEM);
    assign term_valid = (state_q == S_SEND);
    assign term_data  = tx_buf_q;

    assign status_word = {23'b0, 5'(count_q), overrun_q, (state_q == S_SEND),
                          rx_full, !rx_empty};

    always_comb begin
        rdata = 32'h0;
        case (data_src)
            SRC_STATUS: rdata = status_word;
            SRC_TX:     rdata = {24'b0, tx_buf_q};
            SRC_RX:     rdata = rx_empty ? 32'h0 : {24'b0, fifo_q[rd_ptr_q]};
            default:    rdata = mem_rdata;
        endcase
    end

    // FIFO next state; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = kbd_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // TX FSM next state. A data write during SEND is dropped and flags an
    // overrun; the overrun set wins over a same-cycle W1C clear.
    always_comb begin
        state_d   = state_q;
        tx_buf_d  = tx_buf_q;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (tx_wr) begin
                    tx_buf_d = wdata[7:0];
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (term_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tx_wr && (state_q == S_SEND)) begin
            overrun_d = 1'b1;
        end else if (status_wr && wdata[3]) begin
            overrun_d = 1'b0;
        end
    end

    // FIFO storage is not reset; resetting the pointers discards its contents.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            tx_buf_q  <= 8'h0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            tx_buf_q  <= tx_buf_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_fb_io_ctrl.sv
// Testbench for fb_io_ctrl (RX_DEPTH=4). Keyboard bytes accepted by the DUT are
// pushed to a scoreboard queue; each keyboard load pops the queue and compares.
module tb_fb_io_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  data_src;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] rdata;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        term_valid;
    logic [7:0]  term_data;
    logic        term_ready;

    int          n_checks;
    int          n_errors;
    logic [7:0]  sb_q [$];

    fb_io_ctrl #(.RX_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_src   (data_src),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .wdata      (wdata),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .rdata      (rdata),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .term_valid (term_valid),
        .term_data  (term_data),
        .term_ready (term_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_status(output logic [31:0] val);
        data_src = 2'b00;
        #2;
        val = rdata;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        logic [31:0] s;
        read_status(s);
        chk_val(tag, s, exp);
    endtask

    // Push one byte; the scoreboard records it only when the DUT can accept it.
    task automatic kbd_push(input logic [7:0] b);
        kbd_valid = 1'b1;
        kbd_data  = b;
        #1;
        if (kbd_ready) sb_q.push_back(b);
        tick();
        kbd_valid = 1'b0;
    endtask

    // Keyboard load: compare rdata against the oldest scoreboard entry.
    task automatic kbd_load(input string tag);
        logic [7:0] e;
        rd_en    = 1'b1;
        data_src = 2'b10;
        #2;
        if (sb_q.size() == 0) begin
            chk_val({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk_val(tag, rdata, {24'b0, e});
        end
        tick();
        rd_en = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] src, input logic [31:0] d);
        wr_en    = 1'b1;
        data_src = src;
        wdata    = d;
        tick();
        wr_en    = 1'b0;
    endtask

    initial begin
        logic [31:0] s;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        data_src   = 2'b00;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wdata      = 32'h0;
        mem_rdata  = 32'hDEAD_BEEF;
        kbd_valid  = 1'b0;
        kbd_data   = 8'h0;
        term_ready = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_val("rst_kbd_ready", 32'(kbd_ready), 32'd1);
        chk_val("rst_term_valid", 32'(term_valid), 32'd0);
        chk_val("rst_term_data", 32'(term_data), 32'd0);
        chk_status("rst_status", 32'h000);

        // Three bytes in, three loads out in order.
        kbd_push(8'h41);
        kbd_push(8'h42);
        kbd_push(8'h43);
        chk_status("three_status", 32'h031);
        kbd_load("pop_41");
        kbd_load("pop_42");
        kbd_load("pop_43");
        chk_status("drained_status", 32'h000);

        // Fill to full, then hold a byte that cannot be accepted.
        for (int i = 0; i < 4; i++) kbd_push(8'(8'h10 + i));
        #1;
        chk_val("full_kbd_ready", 32'(kbd_ready), 32'd0);
        chk_status("full_status", 32'h043);
        kbd_valid = 1'b1;
        kbd_data  = 8'h55;
        tick();
        tick();
        chk_status("held_status", 32'h043);
        // Pop while still offering 0x55: no push this cycle because full.
        kbd_load("full_pop_10");
        #1;
        chk_val("after_pop_kbd_ready", 32'(kbd_ready), 32'd1);
        sb_q.push_back(8'h55);
        tick();
        kbd_valid = 1'b0;
        chk_status("retry_full_status", 32'h043);
        kbd_load("pop_11");
        // Simultaneous push and pop keeps the count at 3.
        kbd_valid = 1'b1;
        kbd_data  = 8'h66;
        sb_q.push_back(8'h66);
        kbd_load("pushpop_12");
        kbd_valid = 1'b0;
        chk_status("pushpop_status", 32'h031);
        kbd_load("pop_13");
        kbd_load("pop_55");
        kbd_load("pop_66");

        // Empty load returns zero and changes nothing.
        rd_en    = 1'b1;
        data_src = 2'b10;
        #2;
        chk_val("empty_load", rdata, 32'h0);
        tick();
        rd_en = 1'b0;
        chk_status("empty_status", 32'h000);

        // Writes to the keyboard target and status have no effect on read-only bits.
        write_reg(2'b10, 32'hFFFF_FFFF);
        write_reg(2'b00, 32'hFFFF_FFF7);
        chk_status("ro_status", 32'h000);

        // Transmit a byte with the terminal stalled.
        write_reg(2'b01, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            chk_val("send_term_valid", 32'(term_valid), 32'd1);
            chk_val("send_term_data", 32'(term_data), 32'h78);
            chk_status("send_status", 32'h004);
            tick();
        end
        data_src = 2'b01;
        #1;
        chk_val("tx_reg_read", rdata, 32'h78);

        // Overrun while sending, then W1C.
        write_reg(2'b01, 32'h0000_0099);
        chk_val("overrun_term_data", 32'(term_data), 32'h78);
        chk_status("overrun_status", 32'h00C);
        write_reg(2'b00, 32'h0000_0008);
        chk_status("w1c_status", 32'h004);

        term_ready = 1'b1;
        tick();
        term_ready = 1'b0;
        #1;
        chk_val("done_term_valid", 32'(term_valid), 32'd0);
        chk_status("done_status", 32'h000);

        // Reset mid-transfer with two bytes queued; push during reset is ignored.
        kbd_push(8'hA1);
        kbd_push(8'hA2);
        write_reg(2'b01, 32'h0000_00AB);
        chk_status("pre_rst_status", 32'h025);
        rst       = 1'b1;
        kbd_valid = 1'b1;
        kbd_data  = 8'hEE;
        tick();
        rst       = 1'b0;
        kbd_valid = 1'b0;
        sb_q.delete();
        #1;
        chk_val("midrst_term_valid", 32'(term_valid), 32'd0);
        chk_val("midrst_kbd_ready", 32'(kbd_ready), 32'd1);
        chk_status("midrst_status", 32'h000);

        // Memory path.
        wr_en    = 1'b1;
        data_src = 2'b11;
        #1;
        chk_val("mem_we_on", 32'(mem_we), 32'd1);
        chk_val("mem_rdata", rdata, 32'hDEAD_BEEF);
        wr_en = 1'b0;
        #1;
        chk_val("mem_we_off", 32'(mem_we), 32'd0);
        data_src = 2'b01;
        wr_en    = 1'b1;
        #1;
        chk_val("mem_we_tx", 32'(mem_we), 32'd0);
        wr_en = 1'b0;
        tick();
        read_status(s);
        chk_val("final_status", s, 32'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
